// File: rtl/sram_fb_arbiter.sv
// Single-port SRAM framebuffer arbiter: alternating READ/WRITE slots, buffered pixel writes.
// Optional full-framebuffer clear engine is compiled in when FB_CLEAR_EN is defined.
`timescale 1ns/1ps
module sram_fb_arbiter #(
   parameter int                SRAM_AW     = 20,
   parameter int                DATA_W      = 16,
   parameter int                X_BITS      = 9,
   parameter int                Y_BITS      = 9,
   parameter int                SCALE_SHIFT = 1,
   parameter int                WFIFO_DEPTH = 8,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = 16'h0000
) (
   input  logic                             iCLK,
   input  logic                             iRST,
   input  logic [9:0]                       iCoord_X,
   input  logic [9:0]                       iCoord_Y,
   input  logic                             iVideo_EN,
   input  logic                             iWr_Valid,
   output logic                             oWr_Ready,
   input  logic [X_BITS-1:0]                iWr_X,
   input  logic [Y_BITS-1:0]                iWr_Y,
   input  logic [DATA_W-1:0]                iWr_Data,
   output logic [DATA_W-1:0]                oPix_Data,
   output logic                             oPix_Valid,
   output logic [$clog2(WFIFO_DEPTH):0]     oFifo_Level,
   input  logic                             iClear,
   output logic                             oClear_Busy,
   output logic [SRAM_AW-1:0]               oSRAM_ADDR,
   output logic [DATA_W-1:0]                oSRAM_DQ,
   output logic                             oSRAM_DQ_OE,
   input  logic [DATA_W-1:0]                iSRAM_DQ,
   output logic                             oSRAM_WE_N,
   output logic                             oSRAM_OE_N,
   output logic                             oSRAM_CE_N,
   output logic                             oSRAM_UB_N,
   output logic                             oSRAM_LB_N
);
   localparam int PW    = $clog2(WFIFO_DEPTH);
   localparam int LW    = PW + 1;
   localparam int FB_AW = X_BITS + Y_BITS;
   localparam int EW    = FB_AW + DATA_W;

   typedef enum logic {SLOT_READ = 1'b0, SLOT_WRITE = 1'b1} slot_t;

   slot_t               slot_r, slot_next;
   logic [EW-1:0]       fifo_mem [WFIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]       level_r;
   logic                push, pop;
   logic                clear_busy;
   logic [FB_AW-1:0]    clear_addr;
   logic [X_BITS-1:0]   rd_x;
   logic [Y_BITS-1:0]   rd_y;
   logic                video_en_r;
   logic [SRAM_AW-1:0]  addr_next;
   logic [DATA_W-1:0]   dq_next;
   logic                we_n_next, oe_n_next, dq_oe_next;

   assign rd_x        = X_BITS'(iCoord_X >> SCALE_SHIFT);
   assign rd_y        = Y_BITS'(iCoord_Y >> SCALE_SHIFT);
   assign oWr_Ready   = ~iRST & (level_r < LW'(WFIFO_DEPTH));
   assign push        = iWr_Valid & oWr_Ready;
   // The head is consumed on the edge that launches the WRITE slot carrying it.
   assign pop         = ~iRST & (slot_r == SLOT_READ) & ~clear_busy & (level_r != '0);
   assign oFifo_Level = level_r;
   assign oClear_Busy = clear_busy;
   assign oSRAM_CE_N  = 1'b0;
   assign oSRAM_UB_N  = 1'b0;
   assign oSRAM_LB_N  = 1'b0;

   // Next-slot selection and the SRAM pin values it will present.
   always_comb begin
      slot_next  = (slot_r == SLOT_READ) ? SLOT_WRITE : SLOT_READ;
      addr_next  = '0;
      dq_next    = '0;
      we_n_next  = 1'b1;
      oe_n_next  = 1'b0;
      dq_oe_next = 1'b0;
      if (slot_next == SLOT_READ) begin
         addr_next = SRAM_AW'({rd_y, rd_x});
      end else if (clear_busy) begin
         addr_next  = SRAM_AW'(clear_addr);
         dq_next    = CLEAR_VALUE;
         we_n_next  = 1'b0;
         oe_n_next  = 1'b1;
         dq_oe_next = 1'b1;
      end else if (level_r != '0) begin
         addr_next  = SRAM_AW'(fifo_mem[rd_ptr_r][EW-1:DATA_W]);
         dq_next    = fifo_mem[rd_ptr_r][DATA_W-1:0];
         we_n_next  = 1'b0;
         oe_n_next  = 1'b1;
         dq_oe_next = 1'b1;
      end else begin
         oe_n_next  = 1'b1;
      end
   end

   // Slot phase and registered SRAM pins.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         slot_r      <= SLOT_READ;
         oSRAM_ADDR  <= '0;
         oSRAM_DQ    <= '0;
         oSRAM_WE_N  <= 1'b1;
         oSRAM_OE_N  <= 1'b0;
         oSRAM_DQ_OE <= 1'b0;
      end else begin
         slot_r      <= slot_next;
         oSRAM_ADDR  <= addr_next;
         oSRAM_DQ    <= dq_next;
         oSRAM_WE_N  <= we_n_next;
         oSRAM_OE_N  <= oe_n_next;
         oSRAM_DQ_OE <= dq_oe_next;
      end
   end

   // Pixel fetch: qualifier sampled with the address, data captured as the READ slot ends.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         video_en_r <= 1'b0;
         oPix_Data  <= '0;
         oPix_Valid <= 1'b0;
      end else begin
         if (slot_r == SLOT_WRITE) begin
            video_en_r <= iVideo_EN;
         end
         if (slot_r == SLOT_READ) begin
            oPix_Valid <= video_en_r;
            oPix_Data  <= video_en_r ? iSRAM_DQ : '0;
         end else begin
            oPix_Valid <= 1'b0;
         end
      end
   end

   // Write FIFO storage.
   always_ff @(posedge iCLK) begin
      if (push) begin
         fifo_mem[wr_ptr_r] <= {iWr_Y, iWr_X, iWr_Data};
      end
   end

   // Write FIFO pointers and occupancy.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({push, pop})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

`ifdef FB_CLEAR_EN
   logic [FB_AW:0] clear_cnt_r;
   logic           clear_busy_r;

   assign clear_busy = clear_busy_r;
   assign clear_addr = clear_cnt_r[FB_AW-1:0];

   // Clear sweep; the extra counter bit marks that the last address has been launched.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         clear_busy_r <= 1'b0;
         clear_cnt_r  <= '0;
      end else if (!clear_busy_r) begin
         if (iClear) begin
            clear_busy_r <= 1'b1;
            clear_cnt_r  <= '0;
         end
      end else if (slot_r == SLOT_READ) begin
         clear_cnt_r <= clear_cnt_r + (FB_AW+1)'(1);
      end else if (clear_cnt_r[FB_AW]) begin
         clear_busy_r <= 1'b0;
      end
   end
`else
   logic unused_clear;
   assign unused_clear = iClear;
   assign clear_busy   = 1'b0;
   assign clear_addr   = '0;
`endif
endmodule

// File: tb/tb_sram_fb_arbiter.sv
// Scoreboard bench for sram_fb_arbiter: stimulus queues expected SRAM writes and pixels,
// a monitor compares them against the pins one cycle step after each rising edge.
`timescale 1ns/1ps
module tb_sram_fb_arbiter;
`ifdef FB_CLEAR_EN
   localparam int TB_XB = 3;
   localparam int TB_YB = 3;
   localparam logic [15:0] EXP_PIX  = 16'h000A;
   localparam logic [19:0] EXP_WADR = 20'h0001D;
`else
   localparam int TB_XB = 9;
   localparam int TB_YB = 9;
   localparam logic [15:0] EXP_PIX  = 16'h3232;
   localparam logic [19:0] EXP_WADR = 20'h00605;
`endif

   logic             iCLK = 1'b0;
   logic             iRST = 1'b1;
   logic [9:0]       iCoord_X = '0, iCoord_Y = '0;
   logic             iVideo_EN = 1'b0, iWr_Valid = 1'b0, iClear = 1'b0;
   logic [TB_XB-1:0] iWr_X = '0;
   logic [TB_YB-1:0] iWr_Y = '0;
   logic [15:0]      iWr_Data = '0;
   logic             oWr_Ready, oPix_Valid, oClear_Busy, oSRAM_DQ_OE;
   logic [15:0]      oPix_Data, oSRAM_DQ, iSRAM_DQ;
   logic [3:0]       oFifo_Level;
   logic [19:0]      oSRAM_ADDR;
   logic             oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N;

   int total = 0, bad = 0, max_level = 0;
   bit skip_wr = 0;
   logic [35:0] wq[$];
   logic [15:0] pq[$];

   sram_fb_arbiter #(.X_BITS(TB_XB), .Y_BITS(TB_YB)) dut (
      .iCLK(iCLK), .iRST(iRST), .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
      .iVideo_EN(iVideo_EN), .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready),
      .iWr_X(iWr_X), .iWr_Y(iWr_Y), .iWr_Data(iWr_Data), .oPix_Data(oPix_Data),
      .oPix_Valid(oPix_Valid), .oFifo_Level(oFifo_Level), .iClear(iClear),
      .oClear_Busy(oClear_Busy), .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_DQ(oSRAM_DQ),
      .oSRAM_DQ_OE(oSRAM_DQ_OE), .iSRAM_DQ(iSRAM_DQ), .oSRAM_WE_N(oSRAM_WE_N),
      .oSRAM_OE_N(oSRAM_OE_N), .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_UB_N(oSRAM_UB_N),
      .oSRAM_LB_N(oSRAM_LB_N));

   // SRAM model: every address reads back its own low 16 bits.
   assign iSRAM_DQ = oSRAM_ADDR[15:0];

   always #5 iCLK = ~iCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %h want nothing", name, act);
   endtask

   function automatic logic [19:0] fb_addr(input int x, input int y);
      int m;
      m = ((y & ((1 << TB_YB) - 1)) << TB_XB) | (x & ((1 << TB_XB) - 1));
      return 20'(m);
   endfunction

   task automatic push_wr(input int x, input int y, input logic [15:0] d);
      int waited = 0;
      @(negedge iCLK);
      iWr_Valid = 1'b1;
      iWr_X = TB_XB'(x);
      iWr_Y = TB_YB'(y);
      iWr_Data = d;
      while (!oWr_Ready && waited < 50) begin
         @(negedge iCLK);
         waited++;
      end
      if (!oWr_Ready) chk("push_timeout", {31'b0, oWr_Ready}, 32'd1);
      else wq.push_back({fb_addr(x, y), d});
      @(posedge iCLK);
      #1 iWr_Valid = 1'b0;
   endtask

   task automatic wait_wq_empty(input string name, input int budget);
      int n = 0;
      while (wq.size() != 0 && n < budget) begin
         @(negedge iCLK);
         n++;
      end
      chk(name, wq.size(), 32'd0);
   endtask

   // Monitor: pin protocol checks plus scoreboard pops for writes and pixels.
   initial begin
      bit prev_ok = 0, prev_we = 0, prev_oe = 0;
      logic [35:0] e;
      forever begin
         @(posedge iCLK);
         #1;
         if (iRST) begin
            prev_ok = 0;
         end else begin
            if (int'(oFifo_Level) > max_level) max_level = int'(oFifo_Level);
            chk("ready_vs_level", {31'b0, oWr_Ready}, {31'b0, (oFifo_Level < 4'd8)});
            if (prev_ok) chk("slot_alternate", {31'b0, oSRAM_OE_N}, {31'b0, !prev_oe});
            if (!oSRAM_WE_N) begin
               chk("wr_strobes", {oSRAM_OE_N, oSRAM_DQ_OE}, 2'b11);
               if (prev_ok) chk("wr_adjacent", {31'b0, prev_we}, 32'd0);
               if (!skip_wr) begin
                  if (wq.size() == 0) fail_now("wr_unexpected", oSRAM_ADDR);
                  else begin
                     e = wq.pop_front();
                     chk("wr_addr", oSRAM_ADDR, e[35:16]);
                     chk("wr_data", oSRAM_DQ, e[15:0]);
                  end
               end
            end
            if (!oSRAM_OE_N) chk("rd_strobes", {oSRAM_WE_N, oSRAM_DQ_OE}, 2'b10);
            if (oPix_Valid) begin
               if (pq.size() == 0) fail_now("pix_unexpected", oPix_Data);
               else chk("pix_data", oPix_Data, pq.pop_front());
            end
            prev_we = !oSRAM_WE_N;
            prev_oe = oSRAM_OE_N;
            prev_ok = 1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state.
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      chk("rst_we_n", {31'b0, oSRAM_WE_N}, 32'd1);
      chk("rst_oe_n", {31'b0, oSRAM_OE_N}, 32'd0);
      chk("rst_dq_oe", {31'b0, oSRAM_DQ_OE}, 32'd0);
      chk("rst_addr", oSRAM_ADDR, 32'd0);
      chk("rst_pix", {oPix_Valid, oPix_Data}, 32'd0);
      chk("rst_level", oFifo_Level, 32'd0);
      chk("rst_ready", {31'b0, oWr_Ready}, 32'd0);
      chk("rst_busy", {31'b0, oClear_Busy}, 32'd0);
      chk("const_pins", {oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N}, 32'd0);
      iRST = 1'b0;
      #1 chk("ready_after_rst", {31'b0, oWr_Ready}, 32'd1);

      // Single write.
      push_wr(5, 3, 16'hF0F0);
      chk("single_addr_model", wq[0][35:16], EXP_WADR);
      wait_wq_empty("single_write_done", 3);

      // Readout with one qualified sample.
      pq.push_back(EXP_PIX);
      @(negedge iCLK);
      iCoord_X = 10'd100;
      iCoord_Y = 10'd50;
      iVideo_EN = 1'b1;
      repeat (2) @(negedge iCLK);
      iVideo_EN = 1'b0;
      n = 0;
      while (pq.size() != 0 && n < 6) begin
         @(negedge iCLK);
         n++;
      end
      chk("pix_consumed", pq.size(), 32'd0);

      // Blanking: output forced to zero, no valid.
      iCoord_X = 10'd7;
      iCoord_Y = 10'd9;
      repeat (4) @(negedge iCLK);
      for (int i = 0; i < 4; i++) begin
         chk("blank_pix", {oPix_Valid, oPix_Data}, 32'd0);
         @(negedge iCLK);
      end

      // Backpressure: 20 back-to-back pushes.
      for (int i = 0; i < 20; i++) push_wr(i, i + 1, 16'hA000 + 16'(i));
      wait_wq_empty("burst_done", 60);
      chk("burst_max_level", max_level, 32'd8);
      chk("burst_level_end", oFifo_Level, 32'd0);

`ifdef FB_CLEAR_EN
      // Clear sweep first, then queued writes.
      for (int i = 0; i < 64; i++) wq.push_back({20'(i), 16'h0000});
      @(negedge iCLK);
      iClear = 1'b1;
      @(negedge iCLK);
      iClear = 1'b0;
      chk("clear_busy_start", {31'b0, oClear_Busy}, 32'd1);
      n = 1;
      push_wr(1, 2, 16'h1111);
      push_wr(3, 4, 16'h2222);
      push_wr(5, 6, 16'h3333);
      n = n + 3;
      while (oClear_Busy && n < 300) begin
         @(negedge iCLK);
         n++;
      end
      chk("clear_len_ok", {31'b0, (n >= 128 && n <= 129)}, 32'd1);
      wait_wq_empty("clear_then_fifo", 20);

      // Reset mid-clear aborts the sweep.
      skip_wr = 1'b1;
      @(negedge iCLK);
      iClear = 1'b1;
      @(negedge iCLK);
      iClear = 1'b0;
      repeat (20) @(negedge iCLK);
      iRST = 1'b1;
      @(posedge iCLK);
      #1;
      chk("abort_busy", {31'b0, oClear_Busy}, 32'd0);
      chk("abort_we_n", {31'b0, oSRAM_WE_N}, 32'd1);
      @(negedge iCLK);
      iRST = 1'b0;
      wq.delete();
      skip_wr = 1'b0;
      repeat (30) @(negedge iCLK);
      chk("abort_still_idle", {31'b0, oClear_Busy}, 32'd0);
`else
      // iClear has no effect in this build.
      @(negedge iCLK);
      iClear = 1'b1;
      @(negedge iCLK);
      iClear = 1'b0;
      repeat (6) @(negedge iCLK);
      chk("clear_ignored", {31'b0, oClear_Busy}, 32'd0);
`endif

      repeat (4) @(negedge iCLK);
      chk("final_wq_empty", wq.size(), 32'd0);
      chk("final_pq_empty", pq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sram_fb_arbiter.md
Name: sram_fb_arbiter

Overview:
- Parametrised SRAM framebuffer arbiter: time-multiplexes one async single-port SRAM between VGA pixel readout and a buffered pixel-write port.
- Sits between the VGA controller (coordinate/colour interface) and the SRAM pins. The drawing engine (e.g. random walker) pushes pixel writes through a FIFO instead of stealing the bus directly.
- Read/write slots alternate deterministically, so display fetch never starves.

Parameters:
- SRAM_AW, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- X_BITS, 9, framebuffer X address bits.
- Y_BITS, 9, framebuffer Y address bits. X_BITS+Y_BITS <= SRAM_AW.
- SCALE_SHIFT, 1, display coordinates are right-shifted by this before addressing (pixel doubling).
- WFIFO_DEPTH, 8, write FIFO entries; power of 2, >= 2.
- CLEAR_VALUE, 16'h0000, word written by the clear engine.

Ports:
- iCLK  in  1  system/pixel clock
- iRST  in  1  synchronous reset, active high
- iCoord_X  in  10  current display X from VGA controller
- iCoord_Y  in  10  current display Y
- iVideo_EN  in  1  display-active qualifier for iCoord_*
- iWr_Valid  in  1  write request
- oWr_Ready  out  1  FIFO can accept
- iWr_X  in  X_BITS  write pixel X (framebuffer units)
- iWr_Y  in  Y_BITS  write pixel Y
- iWr_Data  in  DATA_W  write word
- oPix_Data  out  DATA_W  fetched pixel word
- oPix_Valid  out  1  oPix_Data updated this cycle
- oFifo_Level  out  log2(WFIFO_DEPTH)+1  FIFO occupancy
- iClear  in  1  start full-framebuffer clear (pulse)
- oClear_Busy  out  1  clear in progress
- oSRAM_ADDR  out  SRAM_AW  address
- oSRAM_DQ  out  DATA_W  write data
- oSRAM_DQ_OE  out  1  tristate enable for DQ (top level drives DQ = OE ? oSRAM_DQ : Z)
- iSRAM_DQ  in  DATA_W  DQ readback
- oSRAM_WE_N, oSRAM_OE_N  out  1 each  SRAM strobes
- oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N  out  1 each  constant 0

Behaviour:
- Reset, synchronous on iRST high:
  - slot phase = READ; FIFO empty; oWr_Ready = 0 while iRST is high, 1 the cycle after.
  - oPix_Data = 0, oPix_Valid = 0, oFifo_Level = 0, oClear_Busy = 0.
  - oSRAM_WE_N = 1, oSRAM_OE_N = 0, oSRAM_DQ_OE = 0, oSRAM_ADDR = 0, oSRAM_DQ = 0.
  - Reset mid-clear or mid-write aborts it immediately; FIFO contents are discarded.
- Address map: addr = {Y, X}, i.e. Y in bits [X_BITS+Y_BITS-1:X_BITS], X in [X_BITS-1:0]; upper SRAM bits are 0.
- Slot phase toggles every cycle (READ, WRITE, READ, ...). All SRAM outputs are registered and show the slot currently in progress.
- READ slot:
  - Address = {iCoord_Y>>SCALE_SHIFT, iCoord_X>>SCALE_SHIFT}, truncated to field widths and sampled in the preceding cycle.
  - OE_N = 0, WE_N = 1, DQ_OE = 0.
  - iSRAM_DQ is captured at the end of the READ slot.
  - On the next cycle oPix_Valid = 1 for one cycle. oPix_Data = captured word if iVideo_EN was 1 at sample time, else 0 with oPix_Valid = 0.
  - oPix_Data holds its value between updates.
  - Latency: 2 cycles from coordinate sample to oPix_Data.
- WRITE slot, priority: clear engine > FIFO head > idle.
  - Write: WE_N = 0, OE_N = 1, DQ_OE = 1 for exactly that cycle; address and data are stable the whole cycle; FIFO pops on this slot.
  - Idle: WE_N = 1, OE_N = 1, DQ_OE = 0.
- FIFO:
  - Push when iWr_Valid & oWr_Ready.
  - oWr_Ready = (registered level < WFIFO_DEPTH). A pop in the same cycle does not enable a push when full.
  - Simultaneous push and pop when non-full: level unchanged.
  - Writes leave in strict push order.
  - Maximum drain rate is 1 per 2 cycles.
  - Pointers wrap modulo WFIFO_DEPTH.
- Write/read hazard: a write to the address being read in the same slot pair is not forwarded; the display shows the new value on the next frame.

Optional Feature:
- Macro FB_CLEAR_EN.
- Defined:
  - iClear high while idle sets oClear_Busy = 1 and starts a counter at 0.
  - Each WRITE slot writes CLEAR_VALUE to addr = counter, then the counter increments, covering all 2^(X_BITS+Y_BITS) addresses.
  - oClear_Busy falls the cycle after the last write.
  - FIFO pops are blocked during clear; pushes continue until full.
  - iClear while busy is ignored.
- Undefined: iClear is ignored; oClear_Busy is tied 0; no clear logic is synthesised.

Test Plan:
- Reset: hold iRST 3 cycles -> WE_N=1, OE_N=0, DQ_OE=0, oPix_Valid=0, oFifo_Level=0, oWr_Ready=0 during reset and 1 after.
- Single write: X=5, Y=3, data 16'hF0F0 -> within 3 cycles, one WRITE slot with ADDR=20'h00605, DQ=16'hF0F0, WE_N=0 and DQ_OE=1 for exactly 1 cycle.
- Readout: SRAM model returns data = addr[15:0]; iCoord_X=100, iCoord_Y=50, iVideo_EN=1 -> 2 cycles later oPix_Valid=1, oPix_Data=16'h3232 (addr {25,50} = 20'h03232).
- Blanking: iVideo_EN=0 -> oPix_Valid=0, oPix_Data=0; SRAM reads continue alternating.
- Backpressure: 20 back-to-back pushes with WFIFO_DEPTH=8 -> oWr_Ready drops when level=8, no push is lost or duplicated, all 20 writes appear in order, never two WRITE strobes in adjacent cycles.
- FB_CLEAR_EN with X_BITS=Y_BITS=3, CLEAR_VALUE=16'h0000: pulse iClear, push 3 writes -> 64 clear writes to addresses 0..63 first, then the 3 FIFO writes; oClear_Busy high for ~128 cycles. Asserting iRST mid-clear -> oClear_Busy=0 next cycle and no further writes.
